// File: rtl/pipo_rr_load_sequencer.sv
// rtl/pipo_rr_load_sequencer.sv - round-robin sequencer loading a shared PIPO register
module pipo_rr_load_sequencer #(
    parameter int NREQ        = 4,
    parameter int WIDTH       = 4,
    parameter int HOLD_CYCLES = 2,
    localparam int PW         = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_i,
    input  logic [NREQ*WIDTH-1:0]   data_in_i,
    output logic [NREQ-1:0]         gnt_o,
    output logic                    load_en_o,
    output logic [WIDTH-1:0]        load_data_o,
    output logic [PW-1:0]           owner_o,
    output logic                    busy_o
);

    // Hold counter sized for 0..HOLD_CYCLES-1; kept at one bit when HOLD is unused.
    localparam int CW      = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int HC_LAST = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic               load_en_q, load_en_d;
    logic [WIDTH-1:0]   load_data_q, load_data_d;
    logic [PW-1:0]      owner_q, owner_d;
    logic               busy_q, busy_d;

    logic               win_found;
    logic [PW-1:0]      win_idx;
    logic [PW-1:0]      cand;

    // Round-robin pick: first asserted request scanning from the pointer upward, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int off = 0; off < NREQ; off++) begin
            cand = PW'((int'(ptr_q) + off) % NREQ);
            if (!win_found && req_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // State and hold counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: IDLE waits for a request, LOAD lasts one cycle, HOLD counts out the guard time.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (|req_i) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cnt_d   = '0;
                state_d = (HOLD_CYCLES > 0) ? ST_HOLD : ST_IDLE;
            end
            ST_HOLD: begin
                if (cnt_q == CW'(HC_LAST)) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output next-values: grant, enable and data are prepared on the IDLE->LOAD edge so
    // every output comes straight from a flop; the pointer advances as LOAD closes.
    always_comb begin
        gnt_d       = '0;
        load_en_d   = 1'b0;
        load_data_d = load_data_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        busy_d      = (state_d != ST_IDLE);
        if (state_q == ST_IDLE && win_found) begin
            gnt_d[win_idx] = 1'b1;
            load_en_d      = 1'b1;
            load_data_d    = data_in_i[int'(win_idx)*WIDTH +: WIDTH];
            owner_d        = win_idx;
        end
        if (state_q == ST_LOAD) begin
            ptr_d = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + PW'(1);
        end
    end

    // Output and priority pointer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt_q       <= '0;
            load_en_q   <= 1'b0;
            load_data_q <= '0;
            owner_q     <= '0;
            busy_q      <= 1'b0;
            ptr_q       <= '0;
        end else begin
            gnt_q       <= gnt_d;
            load_en_q   <= load_en_d;
            load_data_q <= load_data_d;
            owner_q     <= owner_d;
            busy_q      <= busy_d;
            ptr_q       <= ptr_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign load_en_o   = load_en_q;
    assign load_data_o = load_data_q;
    assign owner_o     = owner_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_pipo_rr_load_sequencer.sv
// tb/tb_pipo_rr_load_sequencer.sv - table-driven bench for the round-robin load sequencer
module tb_pipo_rr_load_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req0 = '0, req1 = '0;
    logic [15:0] din0 = '0, din1 = '0;
    logic [3:0]  gnt0, gnt1, ld0, ld1;
    logic        le0, le1, busy0, busy1;
    logic [1:0]  own0, own1;
    logic [11:0] out0, out1;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    pipo_rr_load_sequencer #(.NREQ(4), .WIDTH(4), .HOLD_CYCLES(2)) u0 (
        .clk(clk), .reset(reset), .req_i(req0), .data_in_i(din0),
        .gnt_o(gnt0), .load_en_o(le0), .load_data_o(ld0), .owner_o(own0), .busy_o(busy0)
    );

    pipo_rr_load_sequencer #(.NREQ(4), .WIDTH(4), .HOLD_CYCLES(0)) u1 (
        .clk(clk), .reset(reset), .req_i(req1), .data_in_i(din1),
        .gnt_o(gnt1), .load_en_o(le1), .load_data_o(ld1), .owner_o(own1), .busy_o(busy1)
    );

    assign out0 = {gnt0, le0, ld0, own0, busy0};
    assign out1 = {gnt1, le1, ld1, own1, busy1};

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [15:0] din;
        logic [3:0]  gnt;
        logic        le;
        logic [3:0]  ld;
        logic [1:0]  own;
        logic        busy;
    } vec_t;

    vec_t tv[$];

    function automatic void add(input logic rst, input logic [3:0] req, input logic [15:0] din,
                                input logic [3:0] gnt, input logic le, input logic [3:0] ld,
                                input logic [1:0] own, input logic busy);
        vec_t v;
        v.rst = rst; v.req = req; v.din = din;
        v.gnt = gnt; v.le = le; v.ld = ld; v.own = own; v.busy = busy;
        tv.push_back(v);
    endfunction

    // One grant period with HOLD_CYCLES=2: LOAD row, two HOLD rows, one IDLE row.
    function automatic void add_grant(input logic [3:0] req, input logic [15:0] din,
                                      input int g, input logic [3:0] ld);
        add(1'b0, req, din, 4'(1 << g), 1'b1, ld, 2'(g), 1'b1);
        add(1'b0, req, din, 4'h0, 1'b0, ld, 2'(g), 1'b1);
        add(1'b0, req, din, 4'h0, 1'b0, ld, 2'(g), 1'b1);
        add(1'b0, req, din, 4'h0, 1'b0, ld, 2'(g), 1'b0);
    endfunction

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got gnt=%b le=%b ld=%h own=%0d busy=%b, want gnt=%b le=%b ld=%h own=%0d busy=%b",
                     name, act[11:8], act[7], act[6:3], act[2:1], act[0],
                     exp[11:8], exp[7], exp[6:3], exp[2:1], exp[0]);
        end
    endtask

    initial begin
        int t2_g[5];
        logic [3:0] t2_ld[5];
        int t3_g[4];
        logic [3:0] t3_ld[4];
        int t6_g[4];
        logic [3:0] t6_ld[4];

        t2_g  = '{0, 1, 2, 3, 0};
        t2_ld = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h1};
        t3_g  = '{0, 2, 0, 2};
        t3_ld = '{4'h5, 4'h7, 4'h5, 4'h7};
        t6_g  = '{0, 1, 0, 1};
        t6_ld = '{4'hC, 4'hD, 4'hE, 4'hD};

        // Reset state
        add(1'b1, 4'h0, 16'h0000, 4'h0, 1'b0, 4'h0, 2'd0, 1'b0);
        // T1: single requester 0, busy for LOAD + 2 HOLD cycles
        add(1'b0, 4'b0001, 16'h000A, 4'b0001, 1'b1, 4'hA, 2'd0, 1'b1);
        add(1'b0, 4'b0000, 16'h0000, 4'h0, 1'b0, 4'hA, 2'd0, 1'b1);
        add(1'b0, 4'b0000, 16'h0000, 4'h0, 1'b0, 4'hA, 2'd0, 1'b1);
        add(1'b0, 4'b0000, 16'h0000, 4'h0, 1'b0, 4'hA, 2'd0, 1'b0);
        add(1'b0, 4'b0000, 16'h0000, 4'h0, 1'b0, 4'hA, 2'd0, 1'b0);
        // T2: all requesting, rotation 0,1,2,3 and wrap back to 0
        add(1'b1, 4'h0, 16'h0000, 4'h0, 1'b0, 4'h0, 2'd0, 1'b0);
        for (int k = 0; k < 5; k++) add_grant(4'b1111, 16'h4321, t2_g[k], t2_ld[k]);
        // T3: requesters 0 and 2 only
        add(1'b1, 4'h0, 16'h0000, 4'h0, 1'b0, 4'h0, 2'd0, 1'b0);
        for (int k = 0; k < 4; k++) add_grant(4'b0101, 16'h8765, t3_g[k], t3_ld[k]);
        // T4: pointer wrap after grant to 3, then 0 wins over 3
        add(1'b1, 4'h0, 16'h0000, 4'h0, 1'b0, 4'h0, 2'd0, 1'b0);
        add_grant(4'b1000, 16'h9000, 3, 4'h9);
        add_grant(4'b1001, 16'h9002, 0, 4'h2);
        add_grant(4'b1001, 16'h9002, 3, 4'h9);

        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);

        foreach (tv[i]) begin
            @(negedge clk);
            reset = tv[i].rst;
            req0  = tv[i].req;
            din0  = tv[i].din;
            @(posedge clk);
            #1;
            chk($sformatf("row%0d", i), out0,
                {tv[i].gnt, tv[i].le, tv[i].ld, tv[i].own, tv[i].busy});
        end

        // T5: asynchronous reset in the second HOLD cycle, then priority restarts at 0
        @(negedge clk);
        req0 = 4'b0010; din0 = 16'h00B0;
        @(posedge clk); #1;
        chk("t5_load", out0, {4'b0010, 1'b1, 4'hB, 2'd1, 1'b1});
        @(negedge clk);
        req0 = 4'b0000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("t5_hold2", out0, {4'b0000, 1'b0, 4'hB, 2'd1, 1'b1});
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("t5_async_rst", out0, 12'h000);
        @(posedge clk); #1;
        chk("t5_rst_held", out0, 12'h000);
        @(negedge clk);
        reset = 1'b0; req0 = 4'b1111; din0 = 16'h4321;
        @(posedge clk); #1;
        chk("t5_first_gnt", out0, {4'b0001, 1'b1, 4'h1, 2'd0, 1'b1});

        // T6: HOLD_CYCLES=0, LOAD every 2 cycles; slice change during LOAD is ignored
        @(negedge clk);
        req0 = 4'b0000;
        req1 = 4'b0011; din1 = 16'h00DC;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk($sformatf("t6_load%0d", k), out1,
                {4'(1 << t6_g[k]), 1'b1, t6_ld[k], 2'(t6_g[k]), 1'b1});
            if (k == 0) begin
                @(negedge clk);
                din1 = 16'h00DE;
                #1;
                chk("t6_data_stable", out1, {4'b0001, 1'b1, 4'hC, 2'd0, 1'b1});
            end
            @(posedge clk); #1;
            chk($sformatf("t6_idle%0d", k), out1,
                {4'b0000, 1'b0, t6_ld[k], 2'(t6_g[k]), 1'b0});
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
